ex_stage: RTL and testbench

//  Execute stage plus EX/MEM pipeline register of the 5-stage RISC-V core.
//  - Consumes the ID/IE register outputs and applies forwarding to rs1/rs2.
//  - Computes the ALU result, resolves branch/jump and registers everything the MEM stage needs.
//  - Optionally hosts an iterative multiplier that stalls the front end while busy.

---
 rtl/ex_if.sv | 64 ++++++
 rtl/ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_ex_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_if
//  Purpose  : Bundles the ID/IE register outputs, forwarding controls, the
//             writeback forwarding value and the EX/MEM register outputs of
//             the execute stage into a single interface.
//  Modports : slave  - execute stage (consumes E-side, drives M-side/redirect)
//             master - upstream/downstream pipeline logic
//  Revision : 1.0  initial release
// ============================================================================
interface ex_if #(
    parameter int XLEN = 32
);
    // ID/IE side
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ImmExtendE;
    logic [4:0]      rdE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;

    // Redirect / hazard outputs
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallE;

    // EX/MEM register outputs
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [4:0]      rdM;
    logic            RegWriteM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;

    modport slave (
        input  rd1E, rd2E, PCE, PCPlus4E, ImmExtendE, rdE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, StallE,
        output ALUResultM, WriteDataM, PCPlus4M, rdM,
        output RegWriteM, MemWriteM, ResultSrcM
    );

    modport master (
        output rd1E, rd2E, PCE, PCPlus4E, ImmExtendE, rdE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, StallE,
        input  ALUResultM, WriteDataM, PCPlus4M, rdM,
        input  RegWriteM, MemWriteM, ResultSrcM
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage plus EX/MEM pipeline register of the 5-stage
//             RISC-V core. Applies operand forwarding, computes the ALU
//             result, resolves branches/jumps and registers the MEM-stage
//             payload. Optional iterative shift-add multiplier (ALU code
//             110) that stalls the front end while busy.
//  Config   : define EX_MUL_EN to include the multiplier; otherwise code 110
//             yields 0 in a single cycle and StallE is tied low.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous, active-high
//             bus    - ex_if.slave: ID/IE inputs, forwarding controls,
//                      ResultW, PCSrcE/PCTargetE/StallE, EX/MEM outputs
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    ex_if.slave       bus
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] sub_res;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mul_res;
    logic            zero;
    logic            stall;

    // ------------------------------------------------------------------
    // Forwarding muxes: 10 = MEM-stage ALU result, 01 = writeback result,
    // 00/11 = register file value.
    // ------------------------------------------------------------------
    always_comb begin
        case (bus.ForwardAE)
            2'b10:   src_a = bus.ALUResultM;
            2'b01:   src_a = bus.ResultW;
            default: src_a = bus.rd1E;
        endcase
        case (bus.ForwardBE)
            2'b10:   write_data = bus.ALUResultM;
            2'b01:   write_data = bus.ResultW;
            default: write_data = bus.rd2E;
        endcase
    end

    assign src_b   = bus.ALUSrcE ? bus.ImmExtendE : write_data;
    assign sub_res = src_a - src_b;
    assign zero    = (sub_res == '0);

    always_comb begin
        case (bus.ALUControlE)
            3'b000:  alu_res = src_a + src_b;
            3'b001:  alu_res = sub_res;
            3'b010:  alu_res = src_a & src_b;
            3'b011:  alu_res = src_a | src_b;
            3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110:  alu_res = mul_res;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiplier. Operands are captured at issue because the
    // forwarding sources change once bubbles start flowing into MEM.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    mul_state_t      state;
    mul_state_t      state_next;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            is_mul;

    assign is_mul  = (bus.ALUControlE == 3'b110);
    assign mul_res = acc;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mul) begin
                    stall      = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (cnt == CW'(1)) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Only the low XLEN product bits are needed, so the accumulator and
    // multiplicand stay XLEN wide and overflow bits simply fall off.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand  <= src_a;
                        mplier <= src_b;
                        acc    <= '0;
                        cnt    <= CW'(XLEN);
                    end
                end
                S_BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
`else
    assign mul_res = '0;
    assign stall   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Branch/jump resolution. A mul is never a branch, but the redirect is
    // still masked during a stall so it can only fire once.
    // ------------------------------------------------------------------
    assign bus.PCSrcE    = ~stall & (bus.JumpE | (bus.BranchE & zero));
    assign bus.PCTargetE = bus.PCE + bus.ImmExtendE;
    assign bus.StallE    = stall;

    // ------------------------------------------------------------------
    // EX/MEM register: a stall cycle inserts an all-zero bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
            bus.rdM        <= '0;
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= '0;
        end else begin
            bus.ALUResultM <= alu_res;
            bus.WriteDataM <= write_data;
            bus.PCPlus4M   <= bus.PCPlus4E;
            bus.rdM        <= bus.rdE;
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ResultSrcM <= bus.ResultSrcE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Directed, table-driven bench for ex_stage: reset, ALU ops,
//             forwarding, branch/jump redirect, and (with EX_MUL_EN) the
//             iterative multiplier including reset while busy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ex_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        alusrc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] resw;
        logic [31:0] pc;
        logic        jump;
        logic        branch;
        logic [4:0]  rd;
        logic        regw;
        logic        memw;
        logic [1:0]  rsrc;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
        logic        exp_pcsrc;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [2:0] ctl, input logic [31:0] rd1, input logic [31:0] rd2,
        input logic [31:0] imm, input logic alusrc, input logic [1:0] fa,
        input logic [1:0] fb, input logic [31:0] resw, input logic [31:0] pc,
        input logic jump, input logic branch, input logic [4:0] rd,
        input logic regw, input logic memw, input logic [1:0] rsrc,
        input logic [31:0] exp_alu, input logic [31:0] exp_wd, input logic exp_pcsrc);
        vec_t v;
        v.ctl = ctl; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.alusrc = alusrc;
        v.fa = fa; v.fb = fb; v.resw = resw; v.pc = pc; v.jump = jump;
        v.branch = branch; v.rd = rd; v.regw = regw; v.memw = memw; v.rsrc = rsrc;
        v.exp_alu = exp_alu; v.exp_wd = exp_wd; v.exp_pcsrc = exp_pcsrc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ALUControlE = v.ctl;
        bus.rd1E        = v.rd1;
        bus.rd2E        = v.rd2;
        bus.ImmExtendE  = v.imm;
        bus.ALUSrcE     = v.alusrc;
        bus.ForwardAE   = v.fa;
        bus.ForwardBE   = v.fb;
        bus.ResultW     = v.resw;
        bus.PCE         = v.pc;
        bus.PCPlus4E    = v.pc + 32'd4;
        bus.JumpE       = v.jump;
        bus.BranchE     = v.branch;
        bus.rdE         = v.rd;
        bus.RegWriteE   = v.regw;
        bus.MemWriteE   = v.memw;
        bus.ResultSrcE  = v.rsrc;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic apply_vec(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        chk($sformatf("v%0d PCSrcE", idx), {31'd0, bus.PCSrcE}, {31'd0, v.exp_pcsrc});
        chk($sformatf("v%0d PCTargetE", idx), bus.PCTargetE, v.pc + v.imm);
        chk($sformatf("v%0d StallE", idx), {31'd0, bus.StallE}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d ALUResultM", idx), bus.ALUResultM, v.exp_alu);
        chk($sformatf("v%0d WriteDataM", idx), bus.WriteDataM, v.exp_wd);
        chk($sformatf("v%0d PCPlus4M", idx), bus.PCPlus4M, v.pc + 32'd4);
        chk($sformatf("v%0d ctrlM", idx),
            {23'd0, bus.rdM, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM},
            {23'd0, v.rd, v.regw, v.memw, v.rsrc});
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fa, input logic [31:0] exp_prod);
        int stalls = 0;
        int bubble_bad = 0;
        bit done = 0;
        drive(mk(3'b110, a, b, 32'h0, 1'b0, fa, 2'b00, 32'h77, 32'h400,
                 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.StallE) done = 1;
            else begin
                stalls++;
                @(posedge clk); #1;
                if (bus.RegWriteM !== 1'b0 || bus.ALUResultM !== 32'h0 || bus.rdM !== 5'd0)
                    bubble_bad++;
            end
        end
        chk("mul stall cycles", stalls, 33);
        chk("mul bubbles", bubble_bad, 0);
        @(posedge clk); #1;
        chk("mul ALUResultM", bus.ALUResultM, exp_prod);
        chk("mul RegWriteM/rdM", {26'd0, bus.RegWriteM, bus.rdM}, {26'd0, 1'b1, 5'd9});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    vec_t vecs[18];

    initial begin
        vecs[0]  = mk(3'b000, 32'd7, 32'h55, 32'hFFFF_FFFD, 1, 2'b00, 2'b00, 0, 32'h10, 0, 0, 5'd5, 1, 0, 2'b00, 32'd4, 32'h55, 0);
        vecs[1]  = mk(3'b101, 32'hFFFF_FFFF, 32'd1, 0, 0, 2'b00, 2'b00, 0, 32'h14, 0, 0, 5'd6, 1, 0, 2'b00, 32'd1, 32'd1, 0);
        vecs[2]  = mk(3'b101, 32'd1, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 32'h18, 0, 0, 5'd7, 1, 0, 2'b00, 32'd0, 32'hFFFF_FFFF, 0);
        vecs[3]  = mk(3'b010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 0, 0, 2'b00, 2'b00, 0, 32'h1C, 0, 0, 5'd8, 1, 0, 2'b00, 32'h00F0_F000, 32'h0FF0_F0F0, 0);
        vecs[4]  = mk(3'b011, 32'hF0F0_FF00, 32'h0FF0_F0F0, 0, 0, 2'b00, 2'b00, 0, 32'h20, 0, 0, 5'd9, 0, 1, 2'b01, 32'hFFF0_FFF0, 32'h0FF0_F0F0, 0);
        vecs[5]  = mk(3'b000, 32'h10, 32'h0, 0, 0, 2'b00, 2'b00, 0, 32'h24, 0, 0, 5'd10, 1, 0, 2'b10, 32'h10, 32'h0, 0);
        vecs[6]  = mk(3'b001, 32'hDEAD, 32'h5, 0, 0, 2'b10, 2'b00, 32'h99, 32'h28, 0, 0, 5'd11, 1, 0, 2'b00, 32'hB, 32'h5, 0);
        vecs[7]  = mk(3'b001, 32'hDEAD, 32'h5, 0, 0, 2'b01, 2'b00, 32'h20, 32'h2C, 0, 0, 5'd12, 1, 0, 2'b00, 32'h1B, 32'h5, 0);
        vecs[8]  = mk(3'b000, 32'h100, 32'hBEEF, 0, 0, 2'b00, 2'b10, 32'h99, 32'h30, 0, 0, 5'd13, 1, 0, 2'b00, 32'h11B, 32'h1B, 0);
        vecs[9]  = mk(3'b000, 32'h1, 32'hBEEF, 0, 0, 2'b00, 2'b01, 32'h33, 32'h34, 0, 0, 5'd14, 1, 0, 2'b00, 32'h34, 32'h33, 0);
        vecs[10] = mk(3'b001, 32'd9, 32'd2, 0, 0, 2'b11, 2'b11, 32'h99, 32'h38, 0, 0, 5'd15, 1, 0, 2'b00, 32'd7, 32'd2, 0);
        vecs[11] = mk(3'b001, 32'h1234, 32'h1234, 32'h20, 0, 2'b00, 2'b00, 0, 32'h100, 0, 1, 5'd0, 0, 0, 2'b00, 32'h0, 32'h1234, 1);
        vecs[12] = mk(3'b001, 32'h1234, 32'h1235, 32'h20, 0, 2'b00, 2'b00, 0, 32'h100, 0, 1, 5'd0, 0, 0, 2'b00, 32'hFFFF_FFFF, 32'h1235, 0);
        vecs[13] = mk(3'b000, 32'h0, 32'h0, 32'h20, 1, 2'b00, 2'b00, 0, 32'hFFFF_FFF0, 1, 0, 5'd1, 1, 0, 2'b10, 32'h20, 32'h0, 1);
        vecs[14] = mk(3'b000, 32'hFFFF_FFFF, 32'h3, 32'h2, 1, 2'b00, 2'b00, 0, 32'h40, 0, 0, 5'd2, 1, 0, 2'b00, 32'h1, 32'h3, 0);
        vecs[15] = mk(3'b100, 32'h5, 32'h3, 0, 0, 2'b00, 2'b00, 0, 32'h44, 0, 0, 5'd3, 1, 0, 2'b00, 32'h0, 32'h3, 0);
        vecs[16] = mk(3'b111, 32'h5, 32'h3, 0, 0, 2'b00, 2'b00, 0, 32'h48, 0, 0, 5'd4, 1, 0, 2'b00, 32'h0, 32'h3, 0);
        // Equality only through forwarding (ALUResultM is 0 from the previous vector).
        vecs[17] = mk(3'b001, 32'h55, 32'h0, 32'hFFFF_FFF8, 0, 2'b10, 2'b00, 0, 32'h200, 0, 1, 5'd0, 0, 0, 2'b00, 32'h0, 32'h0, 1);

        // ---------------- reset with random inputs ----------------
        drive(vecs[0]);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            vec_t r;
            logic exp_pc;
            r = mk(3'(($urandom_range(0, 5))), $urandom, $urandom, $urandom, 0,
                   ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                   ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                   $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(1, 31)), 1, 1, 2'b11, 0, 0, 0);
            if (c == 1) r.rd2 = r.rd1;
            drive(r);
            exp_pc = r.jump | (r.branch & (r.rd1 == r.rd2));
            @(negedge clk);
            chk("reset PCSrcE", {31'd0, bus.PCSrcE}, {31'd0, exp_pc});
            chk("reset StallE", {31'd0, bus.StallE}, 32'd0);
            @(posedge clk); #1;
            chk("reset ALUResultM", bus.ALUResultM, 32'd0);
            chk("reset WriteDataM/PCPlus4M", bus.WriteDataM | bus.PCPlus4M, 32'd0);
            chk("reset ctrlM", {23'd0, bus.rdM, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM}, 32'd0);
        end
        reset = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < $size(vecs); i++) apply_vec(vecs[i], i);

`ifdef EX_MUL_EN
        // mul 6*7 with operand A forwarded from MEM in the issue cycle
        apply_vec(mk(3'b000, 32'd6, 32'd0, 0, 0, 2'b00, 2'b00, 0, 32'h300, 0, 0, 5'd3, 1, 0, 2'b00, 32'd6, 32'd0, 0), 100);
        run_mul(32'hBAD, 32'd7, 2'b10, 32'd42);
        // back-to-back: issued on the cycle right after DONE
        run_mul(32'hFFFF_FFFF, 32'd2, 2'b00, 32'hFFFF_FFFE);

        // reset while BUSY
        drive(mk(3'b110, 32'd11, 32'd13, 0, 0, 2'b00, 2'b00, 0, 32'h500, 0, 0, 5'd9, 1, 0, 2'b00, 0, 0, 0));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        drive(mk(3'b000, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 0, 32'h504, 0, 0, 5'd9, 1, 0, 2'b00, 0, 0, 0));
        @(posedge clk); #1;
        chk("busy-reset ALUResultM", bus.ALUResultM, 32'd0);
        chk("busy-reset RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        reset = 1'b0;
        apply_vec(mk(3'b000, 32'd2, 32'd3, 0, 0, 2'b00, 2'b00, 0, 32'h508, 0, 0, 5'd0, 0, 0, 2'b00, 32'd5, 32'd3, 0), 101);
        run_mul(32'd3, 32'd5, 2'b00, 32'd15);
`else
        // Multiplier absent: code 110 is a single-cycle op producing 0.
        apply_vec(mk(3'b110, 32'd6, 32'd7, 0, 0, 2'b00, 2'b00, 0, 32'h300, 0, 0, 5'd9, 1, 0, 2'b00, 32'd0, 32'd7, 0), 100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
